// File: rtl/serial_word_feeder_if.sv
// Word-side handshake bundle for serial_word_feeder.
// Rotation fields exist only when SERIAL_WORD_FEEDER_ROTATE_EN is defined.
interface serial_word_feeder_if #(
  parameter int MSB = 8
);
  logic [MSB-1:0]         in_data;
  logic                   in_lsb_first;
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
  logic [$clog2(MSB)-1:0] in_rot_amt;
  logic                   in_rot_dir;
`endif
  logic                   in_valid;
  logic                   in_ready;

`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
  modport master (output in_data, in_lsb_first, in_rot_amt, in_rot_dir, in_valid,
                  input  in_ready);
  modport slave  (input  in_data, in_lsb_first, in_rot_amt, in_rot_dir, in_valid,
                  output in_ready);
`else
  modport master (output in_data, in_lsb_first, in_valid, input in_ready);
  modport slave  (input  in_data, in_lsb_first, in_valid, output in_ready);
`endif
endinterface

// File: rtl/serial_word_feeder.sv
// Serialises an accepted word onto a shift register's d/en/dir/circular inputs.
// Optional post-load rotation phase under SERIAL_WORD_FEEDER_ROTATE_EN.
module serial_word_feeder #(
  parameter int MSB = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_feeder_if.slave  bus,
  output logic                 d,
  output logic                 en,
  output logic                 dir,
  output logic                 circular,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(MSB);
  localparam logic [CW-1:0] LAST = CW'(MSB - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROT, S_DONE} state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [MSB-1:0]  r_word;
  logic            r_lsb;
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
  logic [CW-1:0]   r_rot_amt;
  logic            r_rot_dir;
`endif
  logic            w_cap;
  logic            r_ready, w_ready;
  logic            r_d, w_d;
  logic            r_en, w_en;
  logic            r_dir, w_dir;
  logic            r_circ, w_circ;
  logic            r_busy, w_busy;
  logic            r_done, w_done;

  function automatic logic pick(input logic [MSB-1:0] word, input logic lsb,
                                input logic [CW-1:0] i);
    return lsb ? word[i] : word[LAST - i];
  endfunction

  // Outputs are computed for the state being entered, so each one is a
  // register: the first bit appears on the accept edge itself.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_cap   = 1'b0;
    w_ready = 1'b0;
    w_d     = 1'b0;
    w_en    = 1'b0;
    w_dir   = 1'b0;
    w_circ  = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (bus.in_valid && r_ready) begin
          w_cap   = 1'b1;
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_ready = 1'b0;
          w_busy  = 1'b1;
          w_en    = 1'b1;
          w_dir   = !bus.in_lsb_first;
          w_d     = pick(bus.in_data, bus.in_lsb_first, '0);
        end
      end
      S_SHIFT: begin
        w_en  = 1'b1;
        w_dir = !r_lsb;
        if (r_cnt != LAST) begin
          w_cnt = r_cnt + CW'(1);
          w_d   = pick(r_word, r_lsb, w_cnt);
        end
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
        else if (r_rot_amt != '0) begin
          w_state = S_ROT;
          w_cnt   = '0;
          w_circ  = 1'b1;
          w_dir   = r_rot_dir;
        end
`endif
        else begin
          w_state = S_DONE;
          w_en    = 1'b0;
          w_dir   = 1'b0;
          w_done  = 1'b1;
        end
      end
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
      S_ROT: begin
        if (r_cnt == r_rot_amt - CW'(1)) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else begin
          w_cnt  = r_cnt + CW'(1);
          w_en   = 1'b1;
          w_circ = 1'b1;
          w_dir  = r_rot_dir;
        end
      end
`endif
      S_DONE: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_word    <= '0;
      r_lsb     <= 1'b0;
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
      r_rot_amt <= '0;
      r_rot_dir <= 1'b0;
`endif
      r_ready   <= 1'b1;
      r_d       <= 1'b0;
      r_en      <= 1'b0;
      r_dir     <= 1'b0;
      r_circ    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ready <= w_ready;
      r_d     <= w_d;
      r_en    <= w_en;
      r_dir   <= w_dir;
      r_circ  <= w_circ;
      r_busy  <= w_busy;
      r_done  <= w_done;
      if (w_cap) begin
        r_word    <= bus.in_data;
        r_lsb     <= bus.in_lsb_first;
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
        r_rot_amt <= bus.in_rot_amt;
        r_rot_dir <= bus.in_rot_dir;
`endif
      end
    end
  end

  assign bus.in_ready = r_ready;
  assign d            = r_d;
  assign en           = r_en;
  assign dir          = r_dir;
  assign circular     = r_circ;
  assign busy         = r_busy;
  assign done         = r_done;
endmodule

// File: tb/tb_serial_word_feeder.sv
// Randomised self-checking bench for serial_word_feeder with a schedule-based
// model and a downstream shift-register model fed from the DUT outputs.
module tb_serial_word_feeder;
  localparam int M = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d, en, dir, circular, busy, done;

  serial_word_feeder_if #(.MSB(M)) sif ();

  serial_word_feeder #(.MSB(M)) dut (
    .clk(clk), .rst(rst), .bus(sif),
    .d(d), .en(en), .dir(dir), .circular(circular), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ready, d, en, dir, circ, busy, done;
  } obs_t;

  localparam obs_t IDLE_OBS = '{ready: 1'b1, default: 1'b0};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  obs_t           exp_q[$];
  logic [M-1:0]   fin_q[$];
  obs_t           cur = IDLE_OBS;
  obs_t           act;
  logic [M-1:0]   ds_out = '0;
  logic [M-1:0]   dseq = '0;
  logic           s_d = 1'b0, s_en = 1'b0, s_dir = 1'b0, s_circ = 1'b0;
  int             rise_q[$];
  int             done_cnt = 0;
  int             rot_cycles = 0;

  function automatic logic [M-1:0] rotate(input logic [M-1:0] w, input int r, input logic right);
    logic [2*M-1:0] t;
    t = {w, w};
    if (right) return t[r +: M];
    return t[M - r +: M];
  endfunction

  // Model: on each accept, queue the full cycle-by-cycle output schedule.
  always @(posedge clk) begin
    int   r;
    logic rd;
    if (s_en) begin
      if (s_circ) ds_out = s_dir ? {ds_out[0], ds_out[M-1:1]} : {ds_out[M-2:0], ds_out[M-1]};
      else        ds_out = s_dir ? {ds_out[M-2:0], s_d} : {s_d, ds_out[M-1:1]};
    end
    if (rst) begin
      exp_q.delete();
      fin_q.delete();
      cur = IDLE_OBS;
    end else begin
      if (cur.ready && sif.in_valid) begin
        r  = 0;
        rd = 1'b0;
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
        r  = int'(sif.in_rot_amt);
        rd = sif.in_rot_dir;
`endif
        for (int i = 0; i < M; i++)
          exp_q.push_back('{ready: 1'b0,
                            d: sif.in_lsb_first ? sif.in_data[i] : sif.in_data[M-1-i],
                            en: 1'b1, dir: !sif.in_lsb_first, circ: 1'b0, busy: 1'b1, done: 1'b0});
        for (int j = 0; j < r; j++)
          exp_q.push_back('{ready: 1'b0, d: 1'b0, en: 1'b1, dir: rd, circ: 1'b1, busy: 1'b1, done: 1'b0});
        exp_q.push_back('{ready: 1'b0, d: 1'b0, en: 1'b0, dir: 1'b0, circ: 1'b0, busy: 1'b1, done: 1'b1});
        fin_q.push_back(rotate(sif.in_data, r, rd));
      end
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_OBS;
    end
    #1;
    cyc++;
    act = '{ready: sif.in_ready, d: d, en: en, dir: dir, circ: circular, busy: busy, done: done};
    n_checks++;
    if (act !== cur) begin
      n_fail++;
      $display("FAIL outputs cycle %0d: got rdy,d,en,dir,circ,busy,done=%b expected %b", cyc, act, cur);
    end
    if (cur.done && fin_q.size() > 0) begin
      logic [M-1:0] f;
      f = fin_q.pop_front();
      n_checks++;
      if (ds_out !== f) begin
        n_fail++;
        $display("FAIL downstream_word cycle %0d: got %h expected %h", cyc, ds_out, f);
      end
    end
    if (en && !s_en) rise_q.push_back(cyc);
    if (en && !circular) dseq = {dseq[M-2:0], d};
    if (circular) rot_cycles++;
    if (done) done_cnt++;
    s_d = d; s_en = en; s_dir = dir; s_circ = circular;
  end

  task automatic lit(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic send(input logic [M-1:0] data, input logic lsb, input int rot, input logic rdir);
    logic acc;
    int   t;
    @(negedge clk);
    sif.in_data      = data;
    sif.in_lsb_first = lsb;
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
    sif.in_rot_amt   = rot[$clog2(M)-1:0];
    sif.in_rot_dir   = rdir;
`endif
    sif.in_valid     = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 4*M) begin
      @(posedge clk);
      acc = sif.in_ready;
      t++;
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
    if (!acc) lit("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 3*M) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1) lit("done_timeout", 0, 1);
  endtask

  initial begin
    int dc;
    logic [M-1:0] w;
    sif.in_data = '0; sif.in_lsb_first = 1'b0; sif.in_valid = 1'b0;
`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
    sif.in_rot_amt = '0; sif.in_rot_dir = 1'b0;
`endif
    repeat (2) @(negedge clk);
    lit("reset_ready", int'(sif.in_ready), 1);
    lit("reset_en_busy_done", int'({en, busy, done, circular}), 0);
    rst = 1'b0;
    @(negedge clk);
    lit("idle_ready_en", int'({sif.in_ready, en}), 2);

    rise_q.delete();
    send(8'hA5, 1'b0, 0, 1'b0);
    wait_done();
    lit("msb_first_word", int'(ds_out), 'hA5);
    lit("msb_first_dseq", int'(dseq), 'b10100101);
    lit("en_to_done_cycles", cyc - rise_q[0], M);

    send(8'h3C, 1'b1, 0, 1'b0);
    wait_done();
    lit("lsb_first_word", int'(ds_out), 'h3C);
    lit("lsb_first_dseq", int'(dseq), 'b00111100);

`ifdef SERIAL_WORD_FEEDER_ROTATE_EN
    @(negedge clk);
    rot_cycles = 0;
    send(8'h81, 1'b0, 3, 1'b1);
    wait_done();
    lit("rot_word", int'(ds_out), 'h30);
    lit("rot_cycles", rot_cycles, 3);
    sif.in_rot_amt = '0;
`endif

    // valid held high across two words: second accept exactly M+2 later
    repeat (3) @(negedge clk);
    rise_q.delete();
    sif.in_valid = 1'b1;
    for (int i = 0; i < M + 4; i++) begin
      sif.in_data      = M'($urandom);
      sif.in_lsb_first = 1'($urandom);
      @(negedge clk);
    end
    sif.in_valid = 1'b0;
    repeat (2*M) @(negedge clk);
    lit("accept_count", rise_q.size(), 2);
    if (rise_q.size() >= 2) lit("accept_spacing", rise_q[1] - rise_q[0], M + 2);

    // reset while bit 4 is on d
    send(8'h5A, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    lit("bit4_en", int'(en), 1);
    dc  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("midreset_en_ready", int'({en, sif.in_ready, busy}), 2);
    repeat (M) @(negedge clk);
    lit("midreset_no_done", done_cnt - dc, 0);
    send(8'hC3, 1'b1, 0, 1'b0);
    wait_done();
    lit("after_reset_word", int'(ds_out), 'hC3);

    for (int n = 0; n < 40; n++) begin
      w = M'($urandom);
      send(w, 1'($urandom), int'($urandom_range(0, M-1)), 1'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, M)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        wait_done();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (M + 4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end
endmodule
